// File: rtl/muldiv_ctrl_pkg.sv
// md_defs: shared FSM encodings, default iteration count and divide-by-zero quotient for muldiv_ctrl
package md_defs;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_FIX = 2'd2;
  localparam int MD_ITER_DEF = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one radix-2 step (is_div=0 shift-add mul, is_div=1 restoring div) on a 64-bit {hi,lo} accumulator with operand b
module md_iter_core (
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [31:0] b,
  output logic [63:0] acc_out
);
  logic [32:0] sum, top;
  logic [31:0] nt;
  logic        ge;
  always_comb begin
    sum = {1'b0, acc_in[63:32]} + {1'b0, acc_in[0] ? b : 32'd0};
    top = acc_in[63:31];
    ge = top >= {1'b0, b};
    nt = ge ? top[31:0] - b : top[31:0];
    acc_out = is_div ? {nt, acc_in[30:0], ge} : {sum, acc_in[31:1]};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative mult/div unit with HI/LO, mthi/mtlo writes, busy/done and ID-stage stall enables (md_*: 1 = proceed)
module muldiv_ctrl
  import md_defs::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_mul,
  input  logic        start_div,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mt_hi_we,
  input  logic        mt_lo_we,
  input  logic [31:0] mt_data,
  input  logic        id_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        md_pc_write,
  output logic        md_if_id_write,
  output logic        md_control_dst
);
  localparam int CW = $clog2(MD_ITER + 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, acc_nx, prod;
  logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, quot, rem;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic start, sa, sb, dz;
  md_iter_core u_core (.is_div(div_q), .acc_in(acc_q), .b(b_q), .acc_out(acc_nx));
  assign start = start_mul | start_div;
  assign sa = is_signed & op_a[31];
  assign sb = is_signed & op_b[31];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;
  assign dz = !start_mul && op_b == 32'd0;
  // Sign correction is applied once in FIX; the iterations work on magnitudes only.
  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (start) begin
          div_d = !start_mul;
          dz_d = dz;
          neg_d = sa ^ sb;
          rneg_d = sa;
          b_d = mag_b;
          // A zero divisor keeps the raw dividend so FIX can return it as the remainder.
          acc_d = {32'd0, dz ? op_a : mag_a};
          cnt_d = CW'(MD_ITER - 1);
          state_d = dz ? S_FIX : S_RUN;
        end else begin
          hi_d = mt_hi_we ? mt_data : hi_q;
          lo_d = mt_lo_we ? mt_data : lo_q;
        end
      S_RUN: begin
        acc_d = acc_nx;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_FIX : S_RUN;
      end
      default: begin
        hi_d = dz_q ? acc_q[31:0] : div_q ? rem : prod[63:32];
        lo_d = dz_q ? DIV0_QUOT : div_q ? quot : prod[31:0];
        done_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign md_pc_write = !(id_md_use && (busy || start));
  assign md_if_id_write = md_pc_write;
  assign md_control_dst = md_pc_write;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed table-driven checks of muldiv_ctrl results, latency, stalls and reset
module tb_muldiv_ctrl;
  localparam int MD_ITER = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic start_mul = 0, start_div = 0, is_signed = 0, mt_hi_we = 0, mt_lo_we = 0, id_md_use = 0;
  logic [31:0] op_a = 0, op_b = 0, mt_data = 0;
  logic [31:0] hi, lo;
  logic busy, done, md_pc_write, md_if_id_write, md_control_dst;
  int pass_n = 0, tot_n = 0;
  typedef struct {
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] a, b, ehi, elo;
  } vec_t;
  vec_t v[10];
  logic [31:0] phi, plo;
  always #5 clk = ~clk;
  muldiv_ctrl #(.MD_ITER(MD_ITER)) dut (
    .clk(clk), .rst(rst), .start_mul(start_mul), .start_div(start_div), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we), .mt_data(mt_data),
    .id_md_use(id_md_use), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .md_pc_write(md_pc_write), .md_if_id_write(md_if_id_write), .md_control_dst(md_control_dst)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic run_vec(input vec_t t, input logic [31:0] ph, input logic [31:0] pl);
    int lat;
    lat = (t.mode == 2'd1 && t.b == 32'd0) ? 1 : MD_ITER + 1;
    @(negedge clk);
    start_mul = t.mode != 2'd1;
    start_div = t.mode != 2'd0;
    is_signed = t.sgn;
    op_a = t.a;
    op_b = t.b;
    @(posedge clk);
    #1 chk("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
    start_mul = 0;
    start_div = 0;
    op_a = 32'h5A5A_5A5A;
    op_b = 32'h0000_0003;
    for (int k = 1; k < lat; k++) begin
      @(posedge clk);
      if (k == lat - 1) begin
        #1 chk("busy_last_run", 64'(busy), 64'd1);
        chk("hilo_held", {hi, lo}, {ph, pl});
      end
    end
    @(posedge clk);
    #1 chk("result_hi", 64'(hi), 64'(t.ehi));
    chk("result_lo", 64'(lo), 64'(t.elo));
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_clear", 64'(busy), 64'd0);
    @(posedge clk);
    #1 chk("done_drop", 64'(done), 64'd0);
  endtask
  initial begin
    v[0] = '{2'd0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[1] = '{2'd1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14};
    v[2] = '{2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3] = '{2'd1, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF};
    v[4] = '{2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[5] = '{2'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    v[6] = '{2'd1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
    v[7] = '{2'd2, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30};
    v[8] = '{2'd1, 1'b0, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999};
    v[9] = '{2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    repeat (2) @(posedge clk);
    #1 chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_md", 64'({md_pc_write, md_if_id_write, md_control_dst}), 64'd7);
    @(negedge clk);
    rst = 0;
    mt_hi_we = 1;
    mt_lo_we = 1;
    mt_data = 32'h1111_2222;
    @(posedge clk);
    #1 chk("mt_both", {hi, lo}, 64'h1111_2222_1111_2222);
    @(negedge clk);
    mt_hi_we = 0;
    mt_lo_we = 0;
    phi = 32'h1111_2222;
    plo = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      run_vec(v[i], phi, plo);
      phi = v[i].ehi;
      plo = v[i].elo;
    end
    // Stall held from the start cycle through FIX; ignored start/mt while busy.
    @(negedge clk);
    id_md_use = 1;
    start_mul = 1;
    is_signed = 0;
    op_a = 32'd3;
    op_b = 32'd4;
    #1 chk("stall_start_cycle", 64'({md_pc_write, md_if_id_write, md_control_dst}), 64'd0);
    for (int k = 0; k <= MD_ITER; k++) begin
      @(negedge clk);
      start_mul = 0;
      start_div = k == 5;
      mt_lo_we = k == 5;
      mt_data = 32'h0000_DEAD;
      #1 chk("stall_busy", 64'({md_pc_write, md_if_id_write, md_control_dst}), 64'd0);
    end
    @(posedge clk);
    #1 chk("stall_release", 64'({md_pc_write, md_if_id_write, md_control_dst}), 64'd7);
    chk("stall_hilo", {hi, lo}, 64'd12);
    @(negedge clk);
    id_md_use = 0;
    // Reset in the middle of RUN.
    start_mul = 1;
    op_a = 32'd5;
    op_b = 32'd5;
    @(negedge clk);
    start_mul = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    id_md_use = 1;
    @(posedge clk);
    #1 chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_md", 64'({md_pc_write, md_if_id_write, md_control_dst}), 64'd7);
    @(negedge clk);
    rst = 0;
    mt_hi_we = 1;
    mt_data = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 chk("mthi_after_rst", {hi, lo}, 64'hA5A5_A5A5_0000_0000);
    // Start and mt write in the same cycle: start wins.
    @(negedge clk);
    id_md_use = 0;
    start_mul = 1;
    op_a = 32'd2;
    op_b = 32'd3;
    mt_data = 32'h0000_FFFF;
    @(posedge clk);
    #1 chk("mt_vs_start", 64'(hi), 64'hA5A5_A5A5);
    @(negedge clk);
    start_mul = 0;
    mt_hi_we = 0;
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk);
        #1 n++;
      end
      chk("done_within_bound", 64'(done), 64'd1);
    end
    chk("mt_vs_start_res", {hi, lo}, 64'd6);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
